// File: rtl/stencil_1d_sched.sv
// Multi-pass sequencer for a fixed-latency stencil kernel. It latches a job, pulses the
// kernel start once per pass, and routes the kernel memory ports onto two ping-pong banks.
module stencil_1d_sched #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned KERNEL_LAT = 70,
  parameter int unsigned PASS_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  // Job command
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [PASS_W-1:0] cmd_passes,
  input  logic [DATA_W-1:0] cmd_c0,
  input  logic [DATA_W-1:0] cmd_c1,
  // Kernel control
  output logic [DATA_W-1:0] k_c0,
  output logic [DATA_W-1:0] k_c1,
  output logic              k_tstart,
  // Kernel read port
  input  logic [ADDR_W-1:0] k_rd_addr,
  input  logic              k_rd_en,
  output logic [DATA_W-1:0] k_rd_data,
  // Kernel write port
  input  logic [ADDR_W-1:0] k_wr_addr,
  input  logic              k_wr_en,
  input  logic [DATA_W-1:0] k_wr_data,
  // Bank A
  output logic [ADDR_W-1:0] bank_a_addr,
  output logic              bank_a_en,
  output logic              bank_a_we,
  output logic [DATA_W-1:0] bank_a_wdata,
  input  logic [DATA_W-1:0] bank_a_rdata,
  // Bank B
  output logic [ADDR_W-1:0] bank_b_addr,
  output logic              bank_b_en,
  output logic              bank_b_we,
  output logic [DATA_W-1:0] bank_b_wdata,
  input  logic [DATA_W-1:0] bank_b_rdata,
  // Status
  output logic              busy,
  output logic              done,
  output logic              result_bank,
  output logic              err
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StRun   = 3'd2;
  localparam logic [2:0] StSwap  = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  // Run counter indexes the RUN cycles 0 .. KERNEL_LAT-1.
  localparam int unsigned CntW = (KERNEL_LAT > 2) ? $clog2(KERNEL_LAT) : 1;
  localparam logic [CntW-1:0] RunLast = CntW'(KERNEL_LAT - 1);

  logic [2:0]        state_q, state_d;
  logic              src_q, src_d;        // 0: A is source, 1: B is source
  logic              result_q, result_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] c0_q, c0_d, c1_q, c1_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [CntW-1:0]   run_q, run_d;
  logic              active;

  // Bank ports are only handed to the kernel while a pass is in flight.
  assign active = (state_q == StStart) || (state_q == StRun);

  // Next-state logic for the pass sequencer.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    c0_d     = c0_q;
    c1_d     = c1_q;
    pass_d   = pass_q;
    run_d    = run_q;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          c0_d    = cmd_c0;
          c1_d    = cmd_c1;
          pass_d  = cmd_passes;
          src_d   = 1'b0;
          state_d = (cmd_passes == '0) ? StDone : StStart;
        end
      end
      StStart: begin
        run_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        if (run_q == RunLast) begin
          state_d = StSwap;
        end else begin
          run_d = run_q + CntW'(1);
        end
      end
      StSwap: begin
        src_d = ~src_q;
        if (pass_q != '0) begin
          pass_d = pass_q - PASS_W'(1);
        end
        state_d = (pass_q > PASS_W'(1)) ? StStart : StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Capture the last destination bank as DONE is entered so it is visible with the pulse.
    result_d = (state_d == StDone) ? src_d : result_q;
    // Any kernel access outside a pass is a stray one.
    err_d    = err_q | (~active & (k_rd_en | k_wr_en));
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      src_q    <= 1'b0;
      result_q <= 1'b0;
      err_q    <= 1'b0;
      c0_q     <= '0;
      c1_q     <= '0;
      pass_q   <= '0;
      run_q    <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      result_q <= result_d;
      err_q    <= err_d;
      c0_q     <= c0_d;
      c1_q     <= c1_d;
      pass_q   <= pass_d;
      run_q    <= run_d;
    end
  end

  // Ping-pong routing of kernel read/write ports onto the two banks.
  always_comb begin
    bank_a_wdata = k_wr_data;
    bank_b_wdata = k_wr_data;
    if (!src_q) begin
      bank_a_addr = k_rd_addr;
      bank_a_en   = active & k_rd_en;
      bank_a_we   = 1'b0;
      bank_b_addr = k_wr_addr;
      bank_b_en   = active & k_wr_en;
      bank_b_we   = active & k_wr_en;
      k_rd_data   = bank_a_rdata;
    end else begin
      bank_b_addr = k_rd_addr;
      bank_b_en   = active & k_rd_en;
      bank_b_we   = 1'b0;
      bank_a_addr = k_wr_addr;
      bank_a_en   = active & k_wr_en;
      bank_a_we   = active & k_wr_en;
      k_rd_data   = bank_b_rdata;
    end
  end

  assign cmd_ready   = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign k_tstart    = (state_q == StStart);
  assign done        = (state_q == StDone);
  assign result_bank = result_q;
  assign err         = err_q;
  assign k_c0        = c0_q;
  assign k_c1        = c1_q;

endmodule

// File: tb/tb_stencil_1d_sched.sv
// Directed bench for stencil_1d_sched with KERNEL_LAT = 8 and two behavioural banks.
module tb_stencil_1d_sched;

  localparam int KL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_passes;
  logic [31:0] cmd_c0, cmd_c1, k_c0, k_c1;
  logic        k_tstart;
  logic [5:0]  k_rd_addr, k_wr_addr;
  logic        k_rd_en, k_wr_en;
  logic [31:0] k_rd_data, k_wr_data;
  logic [5:0]  bank_a_addr, bank_b_addr;
  logic        bank_a_en, bank_a_we, bank_b_en, bank_b_we;
  logic [31:0] bank_a_wdata, bank_a_rdata, bank_b_wdata, bank_b_rdata;
  logic        busy, done, result_bank, err;

  stencil_1d_sched #(
    .ADDR_W(6), .DATA_W(32), .KERNEL_LAT(KL), .PASS_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_passes(cmd_passes),
    .cmd_c0(cmd_c0), .cmd_c1(cmd_c1),
    .k_c0(k_c0), .k_c1(k_c1), .k_tstart(k_tstart),
    .k_rd_addr(k_rd_addr), .k_rd_en(k_rd_en), .k_rd_data(k_rd_data),
    .k_wr_addr(k_wr_addr), .k_wr_en(k_wr_en), .k_wr_data(k_wr_data),
    .bank_a_addr(bank_a_addr), .bank_a_en(bank_a_en), .bank_a_we(bank_a_we),
    .bank_a_wdata(bank_a_wdata), .bank_a_rdata(bank_a_rdata),
    .bank_b_addr(bank_b_addr), .bank_b_en(bank_b_en), .bank_b_we(bank_b_we),
    .bank_b_wdata(bank_b_wdata), .bank_b_rdata(bank_b_rdata),
    .busy(busy), .done(done), .result_bank(result_bank), .err(err)
  );

  always #5 clk = ~clk;

  // Single-port banks, read data one cycle after en; contents reinitialised on rst.
  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        mem_a[i] <= 32'hA000_0000 | 32'(i);
        mem_b[i] <= 32'hB000_0000 | 32'(i);
      end
      bank_a_rdata <= '0;
      bank_b_rdata <= '0;
    end else begin
      if (bank_a_en) begin
        if (bank_a_we) mem_a[bank_a_addr] <= bank_a_wdata;
        bank_a_rdata <= mem_a[bank_a_addr];
      end
      if (bank_b_en) begin
        if (bank_b_we) mem_b[bank_b_addr] <= bank_b_wdata;
        bank_b_rdata <= mem_b[bank_b_addr];
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  int off    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (off %0d): got %0h, expected %0h", name, off, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    off++;
  endtask

  task automatic tick_to(input int n);
    while (off < n) tick();
  endtask

  // Present a job in IDLE; returns one cycle after the accept edge (off = 1).
  task automatic accept(input logic [3:0] p, input logic [31:0] c0, input logic [31:0] c1);
    cmd_passes = p;
    cmd_c0     = c0;
    cmd_c1     = c1;
    cmd_valid  = 1'b1;
    chk("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
    off = 0;
    tick();
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    int          pass;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wdata;
    logic        a_en, a_we;
    logic [5:0]  a_addr;
    logic        b_en, b_we;
    logic [5:0]  b_addr;
  } vec_t;

  vec_t vecs[8];

  task automatic apply_vecs(input int pass);
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].pass == pass) begin
        k_rd_en   = vecs[i].rd_en;
        k_rd_addr = vecs[i].rd_addr;
        k_wr_en   = vecs[i].wr_en;
        k_wr_addr = vecs[i].wr_addr;
        k_wr_data = vecs[i].wdata;
        #1;
        chk($sformatf("vec%0d_a_en", i),   32'(bank_a_en),   32'(vecs[i].a_en));
        chk($sformatf("vec%0d_a_we", i),   32'(bank_a_we),   32'(vecs[i].a_we));
        chk($sformatf("vec%0d_a_addr", i), 32'(bank_a_addr), 32'(vecs[i].a_addr));
        chk($sformatf("vec%0d_b_en", i),   32'(bank_b_en),   32'(vecs[i].b_en));
        chk($sformatf("vec%0d_b_we", i),   32'(bank_b_we),   32'(vecs[i].b_we));
        chk($sformatf("vec%0d_b_addr", i), 32'(bank_b_addr), 32'(vecs[i].b_addr));
        chk($sformatf("vec%0d_wdata", i),
            (vecs[i].pass == 0) ? bank_b_wdata : bank_a_wdata, vecs[i].wdata);
      end
    end
  endtask

  initial begin
    // Pass 0 has A as source; pass 1 has B as source.
    vecs[0] = '{0, 1'b1, 6'd5, 1'b0, 6'd7, 32'h0,     1'b1, 1'b0, 6'd5, 1'b0, 1'b0, 6'd7};
    vecs[1] = '{0, 1'b0, 6'd5, 1'b1, 6'd7, 32'h1234,  1'b0, 1'b0, 6'd5, 1'b1, 1'b1, 6'd7};
    vecs[2] = '{0, 1'b1, 6'd9, 1'b1, 6'd3, 32'hCAFE,  1'b1, 1'b0, 6'd9, 1'b1, 1'b1, 6'd3};
    vecs[3] = '{0, 1'b0, 6'd0, 1'b0, 6'd0, 32'h0,     1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0};
    vecs[4] = '{1, 1'b1, 6'd5, 1'b0, 6'd7, 32'h0,     1'b0, 1'b0, 6'd7, 1'b1, 1'b0, 6'd5};
    vecs[5] = '{1, 1'b0, 6'd5, 1'b1, 6'd7, 32'h1234,  1'b1, 1'b1, 6'd7, 1'b0, 1'b0, 6'd5};
    vecs[6] = '{1, 1'b1, 6'd9, 1'b1, 6'd3, 32'hBEEF,  1'b1, 1'b1, 6'd3, 1'b1, 1'b0, 6'd9};
    vecs[7] = '{1, 1'b0, 6'd0, 1'b0, 6'd0, 32'h0,     1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_passes = '0; cmd_c0 = '0; cmd_c1 = '0;
    k_rd_en = 1'b0; k_rd_addr = '0; k_wr_en = 1'b0; k_wr_addr = '0; k_wr_data = '0;
    tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_tstart",    32'(k_tstart),  32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_result",    32'(result_bank), 32'd0);
    chk("rst_k_c0",      k_c0,           32'd0);
    chk("rst_bank_en",   32'({bank_a_en, bank_a_we, bank_b_en, bank_b_we}), 32'd0);
    rst = 1'b0;
    tick();

    // Three passes: tstart at 1, 11, 21; done at 31.
    accept(4'd3, 32'd2, 32'd3);
    for (int o = 1; o <= 31; o++) begin
      chk("p3_tstart", 32'(k_tstart), 32'((o == 1) || (o == 11) || (o == 21)));
      chk("p3_done",   32'(done),     32'(o == 31));
      chk("p3_busy",   32'(busy),     32'd1);
      if (o == 15) begin
        chk("p3_k_c0", k_c0, 32'd2);
        chk("p3_k_c1", k_c1, 32'd3);
      end
      if (o == 31) chk("p3_result", 32'(result_bank), 32'd1);
      tick();
    end
    chk("p3_idle_ready", 32'(cmd_ready), 32'd1);
    chk("p3_idle_busy",  32'(busy),      32'd0);
    chk("p3_result_hold", 32'(result_bank), 32'd1);

    // Zero passes: straight to DONE, no tstart.
    accept(4'd0, 32'd9, 32'd9);
    chk("p0_tstart", 32'(k_tstart), 32'd0);
    chk("p0_done",   32'(done),     32'd1);
    chk("p0_result", 32'(result_bank), 32'd0);
    chk("p0_ready",  32'(cmd_ready), 32'd0);
    tick();
    chk("p0_ready_again", 32'(cmd_ready), 32'd1);
    chk("p0_done_gone",   32'(done),      32'd0);

    // Routing across two passes, plus read data and write commit.
    accept(4'd2, 32'd1, 32'd1);
    tick_to(2);
    apply_vecs(0);
    k_rd_en = 1'b1; k_rd_addr = 6'd5; k_wr_en = 1'b1; k_wr_addr = 6'd7; k_wr_data = 32'h1234;
    tick();
    k_rd_en = 1'b0; k_wr_en = 1'b0;
    chk("pass1_rd_data", k_rd_data, 32'hA000_0005);
    chk("pass1_wr_mem_b", mem_b[7], 32'h1234);
    tick_to(12);
    apply_vecs(1);
    k_rd_en = 1'b1; k_rd_addr = 6'd5; k_wr_en = 1'b1; k_wr_addr = 6'd7; k_wr_data = 32'h5678;
    tick();
    k_rd_en = 1'b0; k_wr_en = 1'b0;
    chk("pass2_rd_data", k_rd_data, 32'hB000_0005);
    chk("pass2_wr_mem_a", mem_a[7], 32'h5678);
    tick_to(21);
    chk("p2_done",   32'(done),        32'd1);
    chk("p2_result", 32'(result_bank), 32'd0);
    tick();

    // cmd_valid held through a busy job; second job accepted the cycle after done.
    accept(4'd2, 32'd4, 32'd5);
    cmd_passes = 4'd1; cmd_c0 = 32'd7; cmd_c1 = 32'd8; cmd_valid = 1'b1;
    for (int o = 1; o <= 21; o++) begin
      chk("hold_ready_low", 32'(cmd_ready), 32'd0);
      tick();
    end
    chk("hold_k_c0_first", k_c0, 32'd4);
    chk("hold_idle_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("hold_tstart2", 32'(k_tstart), 32'd1);
    chk("hold_k_c0_2",  k_c0, 32'd7);
    chk("hold_k_c1_2",  k_c1, 32'd8);
    tick();
    k_rd_en = 1'b1; k_rd_addr = 6'd2;
    #1;
    chk("hold_src_a_en", 32'(bank_a_en), 32'd1);
    chk("hold_src_b_en", 32'(bank_b_en), 32'd0);
    k_rd_en = 1'b0;
    tick_to(32);
    chk("hold_no_early_done", 32'(done), 32'd0);
    tick();
    chk("hold_done2",   32'(done),        32'd1);
    chk("hold_result2", 32'(result_bank), 32'd1);
    tick();

    // Stray write in IDLE, then in SWAP.
    chk("stray_err_clear", 32'(err), 32'd0);
    k_wr_en = 1'b1; k_wr_addr = 6'd7; k_wr_data = 32'hDEAD;
    #1;
    chk("idle_a_we", 32'(bank_a_we), 32'd0);
    chk("idle_b_we", 32'(bank_b_we), 32'd0);
    chk("idle_b_en", 32'(bank_b_en), 32'd0);
    tick();
    k_wr_en = 1'b0;
    chk("idle_err_set", 32'(err), 32'd1);
    tick(); tick();
    chk("idle_err_sticky", 32'(err), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0; tick();
    chk("err_cleared_by_rst", 32'(err), 32'd0);
    accept(4'd2, 32'd1, 32'd1);
    tick_to(10);
    chk("swap_err_before", 32'(err), 32'd0);
    k_wr_en = 1'b1;
    #1;
    chk("swap_a_we", 32'(bank_a_we), 32'd0);
    chk("swap_b_we", 32'(bank_b_we), 32'd0);
    tick();
    k_wr_en = 1'b0;
    chk("swap_err_set", 32'(err), 32'd1);
    tick_to(22);
    chk("swap_err_sticky", 32'(err), 32'd1);

    // Reset during pass 2 RUN, residual access, then a clean single-pass job.
    accept(4'd2, 32'd1, 32'd1);
    tick_to(14);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy",   32'(busy),      32'd0);
    chk("mid_rst_tstart", 32'(k_tstart),  32'd0);
    chk("mid_rst_done",   32'(done),      32'd0);
    chk("mid_rst_ready",  32'(cmd_ready), 32'd1);
    chk("mid_rst_err",    32'(err),       32'd0);
    k_wr_en = 1'b1; k_wr_addr = 6'd4;
    #1;
    chk("residual_b_we", 32'(bank_b_we), 32'd0);
    chk("residual_a_we", 32'(bank_a_we), 32'd0);
    tick();
    k_wr_en = 1'b0;
    chk("residual_err", 32'(err),  32'd1);
    chk("residual_no_done", 32'(done), 32'd0);
    accept(4'd1, 32'd6, 32'd6);
    chk("p1_tstart", 32'(k_tstart), 32'd1);
    tick_to(KL + 2);
    chk("p1_no_early_done", 32'(done), 32'd0);
    tick();
    chk("p1_done",   32'(done),        32'd1);
    chk("p1_result", 32'(result_bank), 32'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stencil_1d_sched.md
Name: stencil_1d_sched

Overview:
- Multi-pass sequencer for a fixed-latency HIR stencil kernel such as stencil_1d.
- Accepts a job command, registers the kernel's scalar coefficients, and pulses the kernel's tstart once per pass.
- Routes the kernel's read and write memory ports onto two single-port banks in ping-pong fashion, swapping source and destination every pass.
- Reports completion and which bank holds the result. The kernel has no done output, so pass completion is timed by a latency counter.

Parameters:
- ADDR_W, 6: kernel/bank address width.
- DATA_W, 32: data and coefficient width.
- KERNEL_LAT, 70: cycles from the tstart cycle (exclusive) to the kernel's last memory access (inclusive); must be >= 2.
- PASS_W, 4: width of the pass count.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  job request.
- cmd_ready  out  1  high only in IDLE.
- cmd_passes  in  PASS_W  number of kernel passes.
- cmd_c0, cmd_c1  in  DATA_W  coefficients.
- k_c0, k_c1  out  DATA_W  registered coefficients, drive kernel scalar inputs.
- k_tstart  out  1  one-cycle kernel start pulse.
- k_rd_addr  in  ADDR_W, k_rd_en  in  1, k_rd_data  out  DATA_W  kernel read port.
- k_wr_addr  in  ADDR_W, k_wr_en  in  1, k_wr_data  in  DATA_W  kernel write port.
- bank_a_addr  out  ADDR_W, bank_a_en  out  1, bank_a_we  out  1, bank_a_wdata  out  DATA_W, bank_a_rdata  in  DATA_W  bank A.
- bank_b_*  same set of signals for bank B.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- result_bank  out  1  0 = A, 1 = B; valid from the done pulse until the next accept.
- err  out  1  sticky flag for stray kernel access.

Behaviour:
- Reset values: state IDLE; k_tstart, done, busy, err = 0; src = 0 (A); result_bank = 0; k_c0, k_c1 = 0; pass counter = 0; all bank en/we = 0.
- FSM states: IDLE, START, RUN, SWAP, DONE.
- IDLE: cmd_ready = 1. On cmd_valid:
  - latch cmd_c0/cmd_c1 into k_c0/k_c1 and cmd_passes into the pass counter, and set src = 0;
  - go to START, or to DONE if cmd_passes == 0 (no tstart is issued in that case).
- START: k_tstart = 1 for exactly this cycle; run counter cleared; next state RUN.
- RUN: lasts exactly KERNEL_LAT cycles, then SWAP.
- SWAP: one cycle. Toggle src and decrement the pass counter. If the pre-decrement count is > 1, go to START; otherwise go to DONE.
- DONE: one cycle. done = 1; result_bank = src (already toggled, so it names the last destination bank); then IDLE.
- Cycle count: each pass takes KERNEL_LAT + 2 cycles. For an accept at cycle T with P >= 1 passes, done occurs at T + 1 + P*(KERNEL_LAT+2).
- Port routing, combinational, enabled only in START and RUN:
  - the src bank takes k_rd_addr, with en = k_rd_en and we = 0;
  - the dst bank takes k_wr_addr, with en = we = k_wr_en and wdata = k_wr_data;
  - k_rd_data = src bank rdata. Banks return data one cycle after en.
- Gating: in IDLE, SWAP and DONE all bank en/we are forced 0, and any k_rd_en or k_wr_en sets err. err clears only on rst.
- Addresses and wdata pass through unmodified. Pass counter arithmetic is unsigned with no wrap.
- Commands arriving while busy are not accepted (cmd_ready = 0); cmd_valid must hold until accepted.
- Reset mid-operation: immediate return to reset values with no done pulse. The kernel has no reset, so its residual accesses after reset are suppressed and set err.

Test Plan:
1. KERNEL_LAT=8, accept passes=3, c0=2, c1=3 at T -> k_tstart at T+1, T+11, T+21; done at T+31; result_bank=1; k_c0=2, k_c1=3 throughout; busy from T+1 to T+31.
2. Routing during pass 1: k_rd_en=1, k_rd_addr=5 -> bank_a_en=1, bank_a_addr=5, bank_a_we=0. k_wr_en=1, k_wr_addr=7, wdata=0x1234 -> bank_b_we=1, addr 7. Pass 2 mirrors this (reads from B, writes to A). k_rd_data follows the src bank rdata.
3. passes=0 at T -> no k_tstart; done at T+1; result_bank=0; cmd_ready=1 again at T+2.
4. passes=2: cmd_valid held high during busy -> no second accept until IDLE; second job accepted the cycle after done and restarts with src=A.
5. k_wr_en=1 while IDLE, and again during SWAP -> bank_b_we stays 0; err=1 and stays 1 until rst.
6. rst asserted in RUN of pass 2 -> next cycle state IDLE, busy=0, k_tstart=0, no done; a subsequent job passes=1 completes at T+1+(KERNEL_LAT+2) with result_bank=1.
